// File: rtl/datapath_pkg.sv
// Shared datapath definitions: zero-register index, stack-pointer defaults and common types.
// Used by reg_file_rw, which also honours the REG_BYPASS_EN build macro.
package datapath_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int REG_ADDR_W   = $clog2(NUM_REGS_DEF);
    localparam int ZERO_REG     = 0;
    localparam int SP_IDX_DEF   = 15;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]           word_t;

    localparam word_t SP_RESET_DEF = 32'h0000_0FFC;

endpackage

// File: rtl/reg_file_rw_if.sv
// Register-file bus: two read ports, one write port and the committed-write counter.
interface reg_file_rw_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       wr_count;

    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        input  rs_data, rt_data, wr_count
    );

    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        output rs_data, rt_data, wr_count
    );
endinterface

// File: rtl/reg_file_rw_read_port.sv
// One combinational read port: masks index 0 and, when REG_BYPASS_EN is defined,
// forwards the in-flight write data on an address match.
module reg_read_port
    import datapath_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    parameter  int DATA_W   = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
`ifdef REG_BYPASS_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    // Select zero, forwarded write data, or stored contents.
    always_comb begin
        rd_data = {DATA_W{1'b0}};
        if (rd_addr == ADDR_W'(ZERO_REG)) begin
            rd_data = {DATA_W{1'b0}};
`ifdef REG_BYPASS_EN
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
`endif
        end else begin
            rd_data = regs[rd_addr];
        end
    end

endmodule

// File: rtl/reg_file_rw.sv
// General-purpose register file: 2 combinational reads, 1 write per cycle, saturating write counter.
// Same-cycle write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module reg_file_rw
    import datapath_pkg::*;
#(
    parameter  int                NUM_REGS = NUM_REGS_DEF,
    parameter  int                DATA_W   = 32,
    parameter  int                SP_IDX   = SP_IDX_DEF,
    parameter  logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF),
    localparam int                ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_rw_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              wr_commit_s;

    // Next-state for storage and counter; index 0 never takes a write.
    always_comb begin
        regs_d      = regs_q;
        wr_count_d  = wr_count_q;
        wr_commit_s = bus.wr_en && (bus.wr_addr != ADDR_W'(ZERO_REG));
        if (wr_commit_s) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end else begin
                wr_count_d = wr_count_q;
            end
        end else begin
            wr_count_d = wr_count_q;
        end
        regs_d[ZERO_REG] = {DATA_W{1'b0}};
    end

    // State registers; reset loads the stack pointer with its initial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : {DATA_W{1'b0}};
            end
            wr_count_q <= 16'd0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    reg_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_port_a (
        .rd_addr (bus.rs_addr),
        .regs    (regs_q),
`ifdef REG_BYPASS_EN
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
`endif
        .rd_data (bus.rs_data)
    );

    reg_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_port_b (
        .rd_addr (bus.rt_addr),
        .regs    (regs_q),
`ifdef REG_BYPASS_EN
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
`endif
        .rd_data (bus.rt_data)
    );

    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_rw.sv
// Self-checking bench for reg_file_rw: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_rw;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] model [16];
    int          model_count;

    reg_file_rw_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    reg_file_rw dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        model[15]   = 32'h0000_0FFC;
        model_count = 0;
    endfunction

    // Expected read value before the next edge, given the currently driven write.
    function automatic logic [31:0] exp_read(input logic [3:0] a);
        if (a == 4'd0) return 32'd0;
`ifdef REG_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
        return model[a];
    endfunction

    task automatic drive(input logic en, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb);
        bus.wr_en   = en;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rs_addr = ra;
        bus.rt_addr = rb;
    endtask

    // Advance to the rising edge and apply the write rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n && bus.wr_en && bus.wr_addr != 4'd0) begin
            model[bus.wr_addr] = bus.wr_data;
            if (model_count < 65535) model_count = model_count + 1;
        end
    endtask

    task automatic test_reset();
        model_reset();
        drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.rs_addr = 4'(i);
            bus.rt_addr = 4'(15 - i);
            #1;
            n_checks++;
            if (bus.rs_data !== ((i == 15) ? 32'h0000_0FFC : 32'd0)) begin
                n_fail++;
                $display("FAIL reset_rs idx=%0d got %h exp %h", i, bus.rs_data, (i == 15) ? 32'h0000_0FFC : 32'd0);
            end
            n_checks++;
            if (bus.rt_data !== ((i == 0) ? 32'h0000_0FFC : 32'd0)) begin
                n_fail++;
                $display("FAIL reset_rt idx=%0d got %h exp %h", 15 - i, bus.rt_data, (i == 0) ? 32'h0000_0FFC : 32'd0);
            end
        end
        n_checks++;
        if (bus.wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d exp 0", bus.wr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0, 4'd0);
        tick();
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 4'd3, 4'd3);
        #1;
        n_checks++;
        if (bus.rs_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL basic_rs got %h exp DEADBEEF", bus.rs_data);
        end
        n_checks++;
        if (bus.rt_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL basic_rt got %h exp DEADBEEF", bus.rt_data);
        end
        n_checks++;
        if (bus.wr_count !== 16'd1) begin
            n_fail++; $display("FAIL basic_count got %0d exp 1", bus.wr_count);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1'b1, 4'd0, 32'h1234_5678, 4'd0, 4'd0);
        #1;
        n_checks++;
        if (bus.rs_data !== 32'd0) begin
            n_fail++; $display("FAIL zero_same_cycle got %h exp 0", bus.rs_data);
        end
        tick();
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        #1;
        n_checks++;
        if (bus.rt_data !== 32'd0) begin
            n_fail++; $display("FAIL zero_after got %h exp 0", bus.rt_data);
        end
        n_checks++;
        if (bus.wr_count !== 16'(model_count)) begin
            n_fail++; $display("FAIL zero_count got %0d exp %0d", bus.wr_count, model_count);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(1'b1, 4'd7, 32'h1111_2222, 4'd0, 4'd0);
        tick();
        @(negedge clk);
        drive(1'b1, 4'd7, 32'hA5A5_A5A5, 4'd7, 4'd7);
        #1;
        n_checks++;
`ifdef REG_BYPASS_EN
        if (bus.rt_data !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL collision_fwd got %h exp A5A5A5A5", bus.rt_data);
        end
`else
        if (bus.rt_data !== 32'h1111_2222) begin
            n_fail++; $display("FAIL collision_old got %h exp 11112222", bus.rt_data);
        end
`endif
        tick();
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 4'd7, 4'd7);
        #1;
        n_checks++;
        if (bus.rt_data !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL collision_after got %h exp A5A5A5A5", bus.rt_data);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 4'd2, 32'h0000_0055, 4'd2, 4'd15);
        tick();
        @(negedge clk);
        bus.wr_en = 1'b0;
        #1;
        n_checks++;
        if (bus.rs_data !== 32'h0000_0055) begin
            n_fail++; $display("FAIL async_pre got %h exp 55", bus.rs_data);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.rs_data !== 32'd0) begin
            n_fail++; $display("FAIL async_drop got %h exp 0", bus.rs_data);
        end
        n_checks++;
        if (bus.rt_data !== 32'h0000_0FFC) begin
            n_fail++; $display("FAIL async_sp got %h exp FFC", bus.rt_data);
        end
        n_checks++;
        if (bus.wr_count !== 16'd0) begin
            n_fail++; $display("FAIL async_count0 got %0d exp 0", bus.wr_count);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'd2, 32'h0000_0066, 4'd2, 4'd2);
        tick();
        @(negedge clk);
        bus.wr_en = 1'b0;
        #1;
        n_checks++;
        if (bus.wr_count !== 16'd1) begin
            n_fail++; $display("FAIL async_count1 got %0d exp 1", bus.wr_count);
        end
        n_checks++;
        if (bus.rs_data !== 32'h0000_0066) begin
            n_fail++; $display("FAIL async_rewrite got %h exp 66", bus.rs_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (k % 7 == 0) bus.rt_addr = bus.rs_addr;
            #1;
            exp_a = exp_read(bus.rs_addr);
            exp_b = exp_read(bus.rt_addr);
            n_checks++;
            if (bus.rs_data !== exp_a) begin
                n_fail++; $display("FAIL rand_rs k=%0d addr=%0d got %h exp %h", k, bus.rs_addr, bus.rs_data, exp_a);
            end
            n_checks++;
            if (bus.rt_data !== exp_b) begin
                n_fail++; $display("FAIL rand_rt k=%0d addr=%0d got %h exp %h", k, bus.rt_addr, bus.rt_data, exp_b);
            end
            n_checks++;
            if (bus.wr_count !== 16'(model_count)) begin
                n_fail++; $display("FAIL rand_count k=%0d got %0d exp %0d", k, bus.wr_count, model_count);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.rs_addr = 4'd1;
        bus.rt_addr = 4'd1;
        for (int i = 0; i < 65536; i++) begin
            bus.wr_data = 32'(i) ^ 32'hC000_0000;
            tick();
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        #1;
        n_checks++;
        if (bus.wr_count !== 16'(model_count) || model_count != 65535) begin
            n_fail++; $display("FAIL sat_count got %0d exp 65535", bus.wr_count);
        end
        n_checks++;
        if (bus.rs_data !== (32'd65535 ^ 32'hC000_0000)) begin
            n_fail++; $display("FAIL sat_data got %h exp %h", bus.rs_data, 32'd65535 ^ 32'hC000_0000);
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        test_reset();
        test_basic();
        test_zero_reg();
        test_collision();
        test_async_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
